// File: rtl/fetch_queue.sv
// Instruction prefetch buffer: owns the fetch PC, issues in-order imem requests and
// queues returned words with their PC for the fetch stage; flushes on redirect.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    localparam int          CW      = $clog2(DEPTH + 1);
    localparam int          PW      = $clog2(DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] FPC_RST = RESET_PC & ~32'h3;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   fpc_q, fpc_d;
    logic [31:0]   last_pc_q, last_pc_d;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW-1:0] fwr_q, fwr_d, frd_q, frd_d;
    logic [CW-1:0] count_q, count_d, outst_q, outst_d, drop_q, drop_d;

    logic [31:0] q_pc    [DEPTH];
    logic [31:0] q_instr [DEPTH];
    logic [31:0] fl_pc   [DEPTH];

    logic [CW:0] occ;
    logic        accept, rsp_take, push, pop;

    // Dropped responses still occupy in-flight slots, so outst is capped separately
    // to keep the in-flight PC FIFO from overrunning.
    assign occ            = {1'b0, count_q} + {1'b0, outst_q} - {1'b0, drop_q};
    assign imem_req_valid = reset && !redirect && (occ < DEPTH_W) && (outst_q < DEPTH_C);
    assign imem_req_addr  = fpc_q;

    assign accept   = imem_req_valid && imem_req_ready;
    assign rsp_take = imem_rsp_valid && (outst_q != '0);
    assign push     = rsp_take && (drop_q == '0) && !redirect;
    assign pop      = !stall && instr_valid && !redirect;

    assign instr_valid = (count_q != '0);
    assign instr       = instr_valid ? q_instr[rd_q] : NOP;
    assign pc          = instr_valid ? q_pc[rd_q] : last_pc_q;
    assign pc_plus4    = pc + 32'd4;

    // The in-flight PC FIFO is never flushed: every response, dropped or not, pops it,
    // which keeps it aligned with imem order across redirects.
    always_comb begin
        fpc_d     = fpc_q;
        last_pc_d = last_pc_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        fwr_d     = fwr_q;
        frd_d     = frd_q;
        count_d   = count_q;
        outst_d   = outst_q;
        drop_d    = drop_q;
        if (rsp_take) frd_d = frd_q + 1'b1;
        if (redirect) begin
            fpc_d   = redirect_pc & ~32'h3;
            count_d = '0;
            wr_d    = '0;
            rd_d    = '0;
            outst_d = outst_q - CW'(rsp_take);
            drop_d  = outst_q - CW'(rsp_take);
        end else begin
            if (accept) begin
                fpc_d = fpc_q + 32'd4;
                fwr_d = fwr_q + 1'b1;
            end
            if (push) wr_d = wr_q + 1'b1;
            if (pop) begin
                rd_d      = rd_q + 1'b1;
                last_pc_d = q_pc[rd_q];
            end
            if (rsp_take && (drop_q != '0)) drop_d = drop_q - 1'b1;
            count_d = count_q + CW'(push) - CW'(pop);
            outst_d = outst_q + CW'(accept) - CW'(rsp_take);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpc_q     <= FPC_RST;
            last_pc_q <= RESET_PC;
            wr_q      <= '0;
            rd_q      <= '0;
            fwr_q     <= '0;
            frd_q     <= '0;
            count_q   <= '0;
            outst_q   <= '0;
            drop_q    <= '0;
        end else begin
            fpc_q     <= fpc_d;
            last_pc_q <= last_pc_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            fwr_q     <= fwr_d;
            frd_q     <= frd_d;
            count_q   <= count_d;
            outst_q   <= outst_d;
            drop_q    <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_q]    <= fl_pc[frd_q];
            q_instr[wr_q] <= imem_rsp_data;
        end
        if (accept) fl_pc[fwr_q] <= fpc_q;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: behavioural imem with configurable latency and a queue of
// expected PCs checked against each popped head entry.
module tb_fetch_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, instr, pc, pc_plus4;
    logic        redirect, stall, instr_valid;

    int n_cmp = 0;
    int n_bad = 0;
    int lat   = 1;
    int cyc   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] last_pc;

    typedef struct { logic [31:0] a; int due; } pend_t;
    pend_t pend [$];

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect(redirect), .redirect_pc(redirect_pc),
        .stall(stall), .instr_valid(instr_valid), .instr(instr), .pc(pc), .pc_plus4(pc_plus4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0013_0000;
    endfunction

    // imem model: accepts sampled late in the low phase, responses in order after lat cycles
    initial begin
        logic        acc;
        logic [31:0] aa;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            #3;
            acc = imem_req_valid && imem_req_ready;
            aa  = imem_req_addr;
            @(posedge clk);
            cyc++;
            if (!reset) pend.delete();
            else if (acc) pend.push_back('{aa, cyc + lat - 1});
            #1;
            if (reset && pend.size() > 0 && pend[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = f(pend[0].a);
                void'(pend.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
            end
        end
    end

    task automatic test_reset;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || instr !== NOP ||
            pc !== 32'h100 || pc_plus4 !== 32'h104) begin
            n_bad++;
            $display("FAIL reset_state: rv=%b iv=%b instr=%h pc=%h p4=%h required 0 0 00000013 00000100 00000104",
                     imem_req_valid, instr_valid, instr, pc, pc_plus4);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100 || instr_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL first_req: rv=%b addr=%h iv=%b required 1 00000100 0",
                         imem_req_valid, imem_req_addr, instr_valid);
            end
        end
    endtask

    task automatic test_stream(input logic [31:0] start, input int n, input int budget, input bit no_bubble);
        int seen = 0;
        int bub  = 0;
        logic [31:0] e;
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
        for (int c = 0; c < budget && exp_q.size() > 0; c++) begin
            @(negedge clk);
            #1;
            imem_req_ready = 1'b1;
            if (instr_valid) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (pc !== e || instr !== f(e) || pc_plus4 !== e + 32'd4) begin
                    n_bad++;
                    $display("FAIL stream: pc=%h instr=%h p4=%h required %h %h %h",
                             pc, instr, pc_plus4, e, f(e), e + 32'd4);
                end
                last_pc = e;
                seen++;
            end else if (seen > 0) begin
                bub++;
            end else begin
                n_cmp++;
                if (instr !== NOP) begin
                    n_bad++;
                    $display("FAIL empty_nop: instr=%h required 00000013", instr);
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0 || (no_bubble && bub != 0)) begin
            n_bad++;
            $display("FAIL stream_done: left=%0d bubbles=%0d required 0 0", exp_q.size(), bub);
        end
    endtask

    task automatic test_stall;
        @(negedge clk);
        #1;
        stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            n_cmp++;
            if (instr_valid !== 1'b1 || pc !== 32'h140 || instr !== f(32'h140)) begin
                n_bad++;
                $display("FAIL stall_hold: iv=%b pc=%h instr=%h required 1 00000140 %h",
                         instr_valid, pc, instr, f(32'h140));
            end
        end
        n_cmp++;
        if (imem_req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_full: req_valid=%b required 0", imem_req_valid);
        end
        stall = 1'b0;
        test_stream(32'h144, 12, 40, 1'b1);
    endtask

    task automatic drain;
        @(negedge clk);
        #1;
        stall = 1'b1;
        imem_req_ready = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        stall = 1'b0;
        for (int c = 0; c < 20 && instr_valid; c++) begin
            @(negedge clk);
            #1;
        end
        n_cmp++;
        if (instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_timeout: iv=%b required 0", instr_valid);
        end
    endtask

    task automatic test_redirect_inflight;
        drain();
        lat = 3;
        imem_req_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        imem_req_ready = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h200;
        #1;
        n_cmp++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || imem_rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL redir_cycle: rv=%b iv=%b rsp=%b required 0 0 0",
                     imem_req_valid, instr_valid, imem_rsp_valid);
        end
        @(negedge clk);
        #1;
        redirect = 1'b0;
        test_stream(32'h200, 4, 40, 1'b0);
    endtask

    task automatic test_redirect_rsp;
        int k = 0;
        bit hit = 0;
        lat = 1;
        for (int c = 0; c < 30 && !hit; c++) begin
            @(negedge clk);
            #1;
            if (instr_valid) begin
                n_cmp++;
                if (pc !== last_pc + 32'd4) begin
                    n_bad++;
                    $display("FAIL pre_redir: pc=%h required %h", pc, last_pc + 32'd4);
                end
                if (imem_rsp_valid && k >= 3) begin
                    hit = 1;
                    redirect = 1'b1;
                    redirect_pc = 32'h300;
                    #1;
                    n_cmp++;
                    if (imem_req_valid !== 1'b0) begin
                        n_bad++;
                        $display("FAIL redir_noreq: req_valid=%b required 0", imem_req_valid);
                    end
                end else begin
                    last_pc = pc;
                    k++;
                end
            end
        end
        n_cmp++;
        if (!hit) begin
            n_bad++;
            $display("FAIL redir_rsp_timeout: hit=%b required 1", hit);
        end
        @(negedge clk);
        #1;
        redirect = 1'b0;
        n_cmp++;
        if (instr_valid !== 1'b0 || instr !== NOP || pc !== last_pc) begin
            n_bad++;
            $display("FAIL redir_flush: iv=%b instr=%h pc=%h required 0 00000013 %h",
                     instr_valid, instr, pc, last_pc);
        end
        test_stream(32'h300, 4, 30, 1'b0);
    endtask

    task automatic test_reset_mid;
        drain();
        lat = 3;
        stall = 1'b1;
        imem_req_ready = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        n_cmp++;
        if (instr_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset_fill: iv=%b required 1", instr_valid);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0 || instr !== NOP || pc !== 32'h100) begin
            n_bad++;
            $display("FAIL mid_reset: iv=%b rv=%b instr=%h pc=%h required 0 0 00000013 00000100",
                     instr_valid, imem_req_valid, instr, pc);
        end
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b1;
        lat = 1;
        stall = 1'b0;
        test_stream(32'h100, 6, 30, 1'b1);
    endtask

    initial begin
        reset = 1'b0;
        imem_req_ready = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        stall = 1'b0;
        last_pc = '0;
        test_reset();
        test_stream(32'h100, 16, 80, 1'b1);
        test_stall();
        test_redirect_inflight();
        test_redirect_rsp();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
